// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small receive FIFO and per-byte line-error pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits (11-bit frame).
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_pin,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err,
    output logic                          rx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd5,
`endif
        BREAK  = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    logic          sync1_q, sync2_q, rx_prev_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_s, tick_s;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic          full_s, pop_s, push_ok_s;

    assign rx_s   = sync2_q;
    assign tick_s = (cnt_q == '0);

    // Two-flop synchroniser plus previous-sample flop for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx_pin;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d, parity_err_q, parity_err_d;
    // Parity sample and registered parity-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Receive FSM: bit timing, sampling and byte assembly.
    always_comb begin
        state_d     = state_q;
        cnt_d       = tick_s ? FULL_LOAD : cnt_q - 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = HALF_LOAD;
                if (rx_prev_q && !rx_s) begin
                    state_d   = START;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
`else
                    state_d   = (bit_cnt_q == 3'd7) ? STOP : DATA;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                if (tick_s) begin
`ifdef UART_RX_PARITY_EN
                    parity_err_d = parity_bad(shift_q, par_q);
`endif
                    push_s      = rx_s;
                    frame_err_d = !rx_s;
                    state_d     = rx_s ? IDLE : BREAK;
                end else begin
                    state_d = STOP;
                end
            end
            BREAK: begin
                state_d = rx_s ? IDLE : BREAK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer/storage update; a full FIFO still accepts a push when popped the same cycle.
    always_comb begin
        full_s    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop_s     = rx_valid && rx_ready;
        push_ok_s = push_s && (!full_s || pop_s);
        overrun_d = push_s && full_s && !pop_s;
        mem_d     = mem_q;
        if (push_ok_s) begin
            mem_d[wr_q[AW-1:0]] = shift_q;
        end else begin
            mem_d = mem_q;
        end
        wr_d = wr_q + {{AW{1'b0}}, push_ok_s};
        rd_d = rd_q + {{AW{1'b0}}, pop_s};
    end

    // All receiver and FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            mem_q       <= mem_d;
        end
    end

    assign fifo_level = wr_q - rd_q;
    assign rx_valid   = (wr_q != rd_q);
    assign rx_data    = mem_q[rd_q[AW-1:0]];
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign rx_busy    = (state_q != IDLE);
endmodule
